// File: rtl/mips_pkg.sv
// mips_pkg: opcodes, control FSM state encoding and datapath select encodings
package mips_pkg;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_IMM4 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        ADDIEX  = 4'd8,
        ADDIWB  = 4'd9,
        BEQEX   = 4'd10,
        JEX     = 4'd11
    } state_e;
endpackage

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle MIPS control unit sequencing the shared datapath
module mc_control_fsm
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       illegal_op,
    output logic [3:0] state_dbg
);
    state_e state_q, state_d;
    logic   pc_write, pc_write_cond;

    // State register; reset abandons any instruction and restarts at FETCH
    always_ff @(posedge clk) begin
        if (rst) state_q <= FETCH;
        else     state_q <= state_d;
    end

    // Next-state and per-state control decode; reset overrides enables and selects
    always_comb begin
        state_d       = FETCH;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_B;
        alu_op        = ALU_ADD;
        pc_src        = PCSRC_ALU;
        illegal_op    = 1'b0;
        unique case (state_q)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                state_d   = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                alu_src_b = SRCB_IMM4;
                case (opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_R:         state_d = RTYPEEX;
                    OP_BEQ:       state_d = BEQEX;
                    OP_J:         state_d = JEX;
                    default:      illegal_op = 1'b1;
                endcase
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = (opcode == OP_LW) ? MEMRD : (opcode == OP_SW) ? MEMWR : FETCH;
            end
            MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                state_d  = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                state_d   = mem_ready ? FETCH : MEMWR;
            end
            RTYPEEX: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
                state_d   = RTYPEWB;
            end
            RTYPEWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = ADDIWB;
            end
            ADDIWB: reg_write = 1'b1;
            BEQEX: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_src        = PCSRC_ALUOUT;
                pc_write_cond = 1'b1;
            end
            JEX: begin
                pc_src   = PCSRC_JUMP;
                pc_write = 1'b1;
            end
            default: state_d = FETCH;
        endcase
        if (rst) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            iord          = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            reg_dst       = 1'b0;
            mem_to_reg    = 1'b0;
            reg_write     = 1'b0;
            alu_src_a     = 1'b0;
            alu_src_b     = SRCB_FOUR;
            alu_op        = ALU_ADD;
            pc_src        = PCSRC_ALU;
            illegal_op    = 1'b0;
        end
    end

    assign pc_en     = pc_write | (pc_write_cond & zero);
    assign state_dbg = state_q;
endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: table-driven and sequence checks of the multicycle control FSM
module tb_mc_control_fsm;
    import mips_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
    logic       alu_src_a, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic [3:0] state_dbg;

    int passed = 0;
    int total  = 0;

    mc_control_fsm dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_en(pc_en), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .pc_src(pc_src), .illegal_op(illegal_op), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // {pc_en iord mem_read mem_write ir_write reg_dst mem_to_reg reg_write alu_src_a alu_src_b alu_op pc_src illegal_op}
    logic [15:0] act;
    assign act = {pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                  alu_src_a, alu_src_b, alu_op, pc_src, illegal_op};

    localparam logic [15:0] W_FRDY = 16'b1_0_1_0_1_0_0_0_0_01_00_00_0;
    localparam logic [15:0] W_FNR  = 16'b0_0_1_0_0_0_0_0_0_01_00_00_0;
    localparam logic [15:0] W_DEC  = 16'b0_0_0_0_0_0_0_0_0_11_00_00_0;
    localparam logic [15:0] W_ILL  = 16'b0_0_0_0_0_0_0_0_0_11_00_00_1;
    localparam logic [15:0] W_MA   = 16'b0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [15:0] W_MRD  = 16'b0_1_1_0_0_0_0_0_0_00_00_00_0;
    localparam logic [15:0] W_MWB  = 16'b0_0_0_0_0_0_1_1_0_00_00_00_0;
    localparam logic [15:0] W_MWR  = 16'b0_1_0_1_0_0_0_0_0_00_00_00_0;
    localparam logic [15:0] W_REX  = 16'b0_0_0_0_0_0_0_0_1_00_10_00_0;
    localparam logic [15:0] W_RWB  = 16'b0_0_0_0_0_1_0_1_0_00_00_00_0;
    localparam logic [15:0] W_AWB  = 16'b0_0_0_0_0_0_0_1_0_00_00_00_0;
    localparam logic [15:0] W_B1   = 16'b1_0_0_0_0_0_0_0_1_00_01_01_0;
    localparam logic [15:0] W_B0   = 16'b0_0_0_0_0_0_0_0_1_00_01_01_0;
    localparam logic [15:0] W_JEX  = 16'b1_0_0_0_0_0_0_0_0_00_00_10_0;
    localparam logic [15:0] W_RST  = 16'b0_0_0_0_0_0_0_0_0_01_00_00_0;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        z;
        logic        mr;
        logic [3:0]  st;
        logic [15:0] w;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [5:0] op, input logic z, input logic mr,
                       input state_e st, input logic [15:0] w);
        vecs.push_back('{r, op, z, mr, st, w});
    endtask

    task automatic check(input string name, input logic [15:0] a, input logic [15:0] e);
        total++;
        if (a === e) passed++;
        else $display("FAIL %s: got %b expected %b", name, a, e);
    endtask

    task automatic latency(input string name, input logic [5:0] op, input int exp_n);
        int n = 0;
        opcode = op; mem_ready = 1'b1; zero = 1'b0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (state_dbg != 4'(FETCH) && n < 20);
        check(name, 16'(n), 16'(exp_n));
    endtask

    initial begin
        add(0, OP_LW, 0, 1, FETCH, W_FRDY);
        add(0, OP_LW, 0, 1, DECODE, W_DEC);
        add(0, OP_LW, 0, 1, MEMADR, W_MA);
        add(0, OP_LW, 0, 1, MEMRD, W_MRD);
        add(0, OP_LW, 0, 1, MEMWB, W_MWB);
        add(0, OP_SW, 0, 1, FETCH, W_FRDY);
        add(0, OP_SW, 0, 1, DECODE, W_DEC);
        add(0, OP_SW, 0, 1, MEMADR, W_MA);
        add(0, OP_SW, 0, 0, MEMWR, W_MWR);
        add(0, OP_SW, 0, 0, MEMWR, W_MWR);
        add(0, OP_SW, 0, 0, MEMWR, W_MWR);
        add(0, OP_SW, 0, 1, MEMWR, W_MWR);
        add(0, OP_BEQ, 1, 1, FETCH, W_FRDY);
        add(0, OP_BEQ, 1, 1, DECODE, W_DEC);
        add(0, OP_BEQ, 1, 1, BEQEX, W_B1);
        add(0, OP_BEQ, 0, 1, FETCH, W_FRDY);
        add(0, OP_BEQ, 0, 1, DECODE, W_DEC);
        add(0, OP_BEQ, 0, 1, BEQEX, W_B0);
        add(0, OP_R, 0, 1, FETCH, W_FRDY);
        add(0, OP_R, 0, 1, DECODE, W_DEC);
        add(0, OP_R, 0, 1, RTYPEEX, W_REX);
        add(0, OP_R, 0, 1, RTYPEWB, W_RWB);
        add(0, OP_J, 0, 1, FETCH, W_FRDY);
        add(0, OP_J, 0, 1, DECODE, W_DEC);
        add(0, OP_J, 0, 1, JEX, W_JEX);
        add(0, OP_ADDI, 0, 1, FETCH, W_FRDY);
        add(0, OP_ADDI, 0, 1, DECODE, W_DEC);
        add(0, OP_ADDI, 0, 1, ADDIEX, W_MA);
        add(0, OP_ADDI, 0, 1, ADDIWB, W_AWB);
        add(0, OP_LW, 0, 0, FETCH, W_FNR);
        add(0, OP_LW, 0, 1, FETCH, W_FRDY);
        add(0, OP_LW, 0, 1, DECODE, W_DEC);
        add(0, OP_LW, 0, 1, MEMADR, W_MA);
        add(0, OP_LW, 0, 0, MEMRD, W_MRD);
        add(0, OP_LW, 0, 1, MEMRD, W_MRD);
        add(0, OP_LW, 0, 1, MEMWB, W_MWB);
        add(0, 6'b111111, 0, 1, FETCH, W_FRDY);
        add(0, 6'b111111, 0, 1, DECODE, W_ILL);
        add(0, OP_R, 0, 1, FETCH, W_FRDY);
        add(0, OP_R, 0, 1, DECODE, W_DEC);
        add(0, OP_R, 0, 1, RTYPEEX, W_REX);
        add(1, OP_R, 1, 1, RTYPEWB, W_RST);
        add(1, OP_R, 1, 1, FETCH, W_RST);
        add(0, OP_R, 0, 0, FETCH, W_FNR);

        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("reset_state", 16'(state_dbg), 16'(FETCH));
        check("reset_outputs", act, W_RST);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst; opcode = vecs[i].op; zero = vecs[i].z; mem_ready = vecs[i].mr;
            #1;
            check($sformatf("vec%0d_state", i), 16'(state_dbg), 16'(vecs[i].st));
            check($sformatf("vec%0d_out", i), act, vecs[i].w);
        end

        latency("lat_beq", OP_BEQ, 3);
        latency("lat_j", OP_J, 3);
        latency("lat_r", OP_R, 4);
        latency("lat_addi", OP_ADDI, 4);
        latency("lat_sw", OP_SW, 4);
        latency("lat_lw", OP_LW, 5);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Multicycle MIPS control unit that sequences the shared datapath (single memory, single ALU, 2:1/4:1 select muxes) one instruction phase per clock. Decodes the 6-bit opcode captured in the instruction register and drives every mux select and write enable in the datapath. Stalls on a memory-ready handshake and flags unsupported opcodes. Sits between the instruction register and the datapath mux/enable inputs.

## Interface
- No parameters. Opcodes and select encodings are fixed constants.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- opcode  in  6  IR[31:26]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory has completed the current access this cycle
- pc_en  out  1  pc_write | (pc_write_cond & zero)
- iord  out  1  memory address select: 0=PC, 1=ALUOut
- mem_read / mem_write  out  1  memory strobes, held until mem_ready
- ir_write  out  1  load IR
- reg_dst  out  1  0=rt, 1=rd
- mem_to_reg  out  1  0=ALUOut, 1=MDR
- reg_write  out  1  register-file write enable
- alu_src_a  out  1  0=PC, 1=A
- alu_src_b  out  2  00=B, 01=const 4, 10=sign-ext imm, 11=imm<<2
- alu_op  out  2  00=add, 01=sub, 10=use funct
- pc_src  out  2  00=ALU result, 01=ALUOut, 10=jump target
- illegal_op  out  1  one-cycle pulse on unsupported opcode
- state_dbg  out  4  current state encoding

## Operation
- Opcodes: R=000000, lw=100011, sw=101011, beq=000100, addi=001000, j=000010.
- States and transitions:
  - FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00. When mem_ready: ir_write=1, pc_write=1, go DECODE. Otherwise stay, ir_write=0, pc_write=0.
  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Next by opcode: lw/sw/addi -> MEMADR or ADDIEX, R -> RTYPEEX, beq -> BEQEX, j -> JEX, other -> FETCH with illegal_op=1.
  - MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. lw -> MEMRD, sw -> MEMWR.
  - MEMRD: mem_read=1, iord=1; stay until mem_ready, then MEMWB.
  - MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1 -> FETCH.
  - MEMWR: mem_write=1, iord=1; stay until mem_ready, then FETCH.
  - RTYPEEX: alu_src_a=1, alu_src_b=00, alu_op=10 -> RTYPEWB.
  - RTYPEWB: reg_dst=1, mem_to_reg=0, reg_write=1 -> FETCH.
  - ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00 -> ADDIWB.
  - ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1 -> FETCH.
  - BEQEX: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_write_cond=1 -> FETCH.
  - JEX: pc_src=10, pc_write=1 -> FETCH.
- Every output not listed for a state is 0. Selects are don't-care-free: driven to 0 when unused.
- pc_write and pc_write_cond are internal. pc_en is combinational from state, mem_ready and zero.

## Timing
- Reset: on a clock edge with rst=1, state becomes FETCH. While rst=1, all write enables and strobes (pc_en, ir_write, reg_write, mem_read, mem_write) are forced 0 and illegal_op=0. Selects take their FETCH values.
- Reset mid-instruction: abandon the instruction and enter FETCH on the next edge. No partial register or memory write occurs after the reset edge.
- Zero-wait latency (mem_ready=1 always), in cycles from FETCH: beq 3, j 3, R 4, addi 4, sw 4, lw 5.
- Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle. The strobe and address select are held stable throughout the stall.
- illegal_op asserts in the DECODE cycle only. The next state is FETCH, and there are no writes.
- Outputs are combinational from registered state (plus mem_ready in FETCH). The opcode is sampled only in DECODE and MEMADR.

## Structure
- Shared package mips_pkg: opcode constants, state enum (4-bit), encodings for alu_op, alu_src_b and pc_src.
- Single module with a registered next-state process and a combinational output decode. No sub-module.

## Test plan
- Reset: hold rst for 2 cycles mid-RTYPEEX -> state_dbg=FETCH; reg_write, mem_write and pc_en stay 0 for the whole reset window.
- lw, mem_ready=1 -> FETCH, DECODE, MEMADR, MEMRD, MEMWB (5 cycles); reg_write=1 with mem_to_reg=1 and reg_dst=0 only in cycle 5.
- sw with mem_ready low for 3 cycles in MEMWR -> mem_write=1 and iord=1 held for 4 cycles, return to FETCH, reg_write never asserted.
- beq with zero=1, then zero=0 -> pc_en=1 with pc_src=01 in BEQEX for the first case; pc_en=0 for the second; both take 3 cycles.
- R-type then j back-to-back -> RTYPEWB has reg_dst=1 and alu_op=10 in RTYPEEX; JEX has pc_src=10 and pc_en=1.
- opcode=111111 -> illegal_op is a one-cycle pulse in DECODE, next state FETCH, no writes.
